ysyx_22040895_immgen: RTL and testbench
=======================================

Name: ysyx_22040895_immgen

Overview:
Parametrised RISC-V immediate generator for the decode stage. It extracts and extends the immediate for every base instruction format (I/S/B/U/J), CSR zimm and shift amount, for XLEN 32 or 64. It adds a registered output stage with a valid/ready handshake and a 2-entry skid buffer, so decode can stall without losing or duplicating immediates. It sits between instruction fetch/decode and the ID/EX pipeline register.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
SHAMT_W, 6, shift-amount width; 5 when XLEN=32, 6 when XLEN=64.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high (`ysyx_22040895_RstEnable = 1'b1).
in_valid  in  1  inst/fmt valid.
in_ready  out  1  block can accept this cycle.
inst_i  in  32  raw instruction word.
fmt_i  in  3  immediate format code (see Behaviour).
out_valid  out  1  imm_o/err_o valid.
out_ready  in  1  consumer accepts this cycle.
imm_o  out  XLEN  extended immediate.
err_o  out  1  reserved fmt code was used.

Behaviour:
- Format codes and extraction (s = sign-extend to XLEN from bit 31 of inst, z = zero-extend):
  - 0 I: s{inst[31:20]}
  - 1 S: s{inst[31:25], inst[11:7]}
  - 2 B: s{inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  - 3 U: s{inst[31:12], 12'b0}
  - 4 J: s{inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
  - 5 Z: z{inst[19:15]}
  - 6 SH: z{inst[20+SHAMT_W-1:20]}
  - 7 reserved: imm=0, err=1
- err=0 for codes 0-6.
- Storage: output register R (flag ov) and skid register S (flag sv). in_ready = ~sv, combinational from a flop; no combinational path from out_ready to in_ready. out_valid = ov.
- Accept = in_valid & in_ready. Output fire = ov & out_ready.
- Per clock edge:
  - If ~ov or out_ready (R free):
    - if sv: R<=S, sv<=0, ov<=1;
    - else if accept: R<=computed, ov<=1;
    - else ov<=0.
  - Else (R held): if accept: S<=computed, sv<=1. R is unchanged.
- Latency: 1 cycle from accept to out_valid when unstalled. Throughput is 1 per cycle.
- Ordering: strict FIFO. No drop, no duplicate.
- imm_o and err_o are stable while out_valid & ~out_ready.
- Reset: asynchronous. ov=0, sv=0, imm_o=0, err_o=0, so in_ready=1 immediately. Reset mid-transfer discards R and S contents.
- Inputs are ignored when in_ready=0.

Decomposition:
- define.v holds:
  - format codes `ysyx_22040895_IMM_I..IMM_RSV (3-bit);
  - `ysyx_22040895_XLEN default;
  - `ysyx_22040895_RstEnable.
- One sub-module, ysyx_22040895_immgen_dec: purely combinational (inst, fmt) -> (imm, err), parametrised by XLEN and SHAMT_W. The top module instantiates it once and contains the skid/handshake logic.

Test Plan:
- I: inst=0xFFF00093, fmt=0, out_ready=1 -> next cycle out_valid=1, imm=0xFFFF_FFFF_FFFF_FFFF, err=0.
- B/U: inst=0xFE000EE3, fmt=2 -> imm=0xFFFF_FFFF_FFFF_FFFC. inst=0x12345037, fmt=3 -> 0x0000_0000_1234_5000. inst=0x80000037, fmt=3 -> 0xFFFF_FFFF_8000_0000.
- Z/SH/reserved:
  - inst[19:15]=11111, fmt=5 -> imm=0x1F.
  - inst[25:20]=0x3F, fmt=6 -> 0x3F; with XLEN=32, SHAMT_W=5 the same inst gives 0x1F.
  - fmt=7 -> imm=0, err=1.
- Backpressure: out_ready=0, send A,B,C back-to-back with in_valid=1 -> A in R, B in S, in_ready=0, C held. Raise out_ready -> out sequence A,B,C on consecutive cycles, no gaps or duplicates.
- Reset mid-operation: with ov=1, sv=1, assert rst between edges -> out_valid=0, imm_o=0 and in_ready=1 without waiting for a clock edge. After release, the first new input appears 1 cycle after accept.

Source files
------------

// File: rtl/ysyx_22040895_immgen_pkg.sv
// Shared constants for the RISC-V immediate generator.
// Format codes, default datapath width and reset level.
package ysyx_22040895_immgen_pkg;

  localparam logic [2:0] IMM_I   = 3'd0;
  localparam logic [2:0] IMM_S   = 3'd1;
  localparam logic [2:0] IMM_B   = 3'd2;
  localparam logic [2:0] IMM_U   = 3'd3;
  localparam logic [2:0] IMM_J   = 3'd4;
  localparam logic [2:0] IMM_Z   = 3'd5;
  localparam logic [2:0] IMM_SH  = 3'd6;
  localparam logic [2:0] IMM_RSV = 3'd7;

  localparam int XLEN_DEF = 64;

  localparam logic RST_ENABLE = 1'b1;

endpackage

// File: rtl/ysyx_22040895_immgen_dec.sv
// Combinational immediate extraction for all base formats.
// Builds a 32-bit value, then sign- or zero-extends it to XLEN.
module ysyx_22040895_immgen_dec
  import ysyx_22040895_immgen_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = 6
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  logic [31:0] w;
  logic        sgn;
  logic        s31;
  logic        unused_opc;

  assign s31        = inst[31];
  assign unused_opc = ^inst[6:0];

  always_comb begin
    w   = '0;
    sgn = 1'b0;
    err = 1'b0;
    unique case (fmt)
      IMM_I: begin
        w   = {{20{s31}}, inst[31:20]};
        sgn = 1'b1;
      end
      IMM_S: begin
        w   = {{20{s31}}, inst[31:25], inst[11:7]};
        sgn = 1'b1;
      end
      IMM_B: begin
        w   = {{19{s31}}, inst[31], inst[7],
               inst[30:25], inst[11:8], 1'b0};
        sgn = 1'b1;
      end
      IMM_U: begin
        w   = {inst[31:12], 12'b0};
        sgn = 1'b1;
      end
      IMM_J: begin
        w   = {{11{s31}}, inst[31], inst[19:12],
               inst[20], inst[30:21], 1'b0};
        sgn = 1'b1;
      end
      IMM_Z: w = {27'b0, inst[19:15]};
      IMM_SH: w = 32'(inst[20 +: SHAMT_W]);
      default: err = 1'b1;
    endcase
  end

  // w already carries its sign in bit 31 for signed formats
  assign imm = sgn ? XLEN'($signed(w)) : XLEN'(w);

endmodule

// File: rtl/ysyx_22040895_immgen.sv
// Immediate generator with registered output and 2-entry skid.
// in_ready depends only on the skid flag, never on out_ready.
module ysyx_22040895_immgen
  import ysyx_22040895_immgen_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_i,
  input  logic [2:0]      fmt_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_o,
  output logic            err_o
);

  logic [XLEN-1:0] c_imm;
  logic            c_err;
  logic            ov;
  logic            sv;
  logic [XLEN-1:0] r_imm;
  logic            r_err;
  logic [XLEN-1:0] s_imm;
  logic            s_err;
  logic            acc;
  logic            r_free;

  ysyx_22040895_immgen_dec #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_dec (
    .inst (inst_i),
    .fmt  (fmt_i),
    .imm  (c_imm),
    .err  (c_err)
  );

  assign in_ready  = ~sv;
  assign acc       = in_valid & in_ready;
  assign r_free    = ~ov | out_ready;
  assign out_valid = ov;
  assign imm_o     = r_imm;
  assign err_o     = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      ov    <= 1'b0;
      sv    <= 1'b0;
      r_imm <= '0;
      r_err <= 1'b0;
      s_imm <= '0;
      s_err <= 1'b0;
    end else if (r_free) begin
      if (sv) begin
        r_imm <= s_imm;
        r_err <= s_err;
        sv    <= 1'b0;
        ov    <= 1'b1;
      end else if (acc) begin
        r_imm <= c_imm;
        r_err <= c_err;
        ov    <= 1'b1;
      end else begin
        ov    <= 1'b0;
      end
    end else if (acc) begin
      // R stalled: park the new result behind it
      s_imm <= c_imm;
      s_err <= c_err;
      sv    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_immgen.sv
// Directed bench for the immediate generator (XLEN 64 and 32).
// Hand-computed vectors, backpressure ordering and async reset.
module tb_ysyx_22040895_immgen;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst_i;
  logic [2:0]  fmt_i;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] imm_o;
  logic        err_o;

  logic        in_ready32;
  logic        out_valid32;
  logic [31:0] imm32;
  logic        err32;

  int tests = 0;
  int fails = 0;

  ysyx_22040895_immgen #(
    .XLEN    (64),
    .SHAMT_W (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst_i    (inst_i),
    .fmt_i     (fmt_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_o     (imm_o),
    .err_o     (err_o)
  );

  ysyx_22040895_immgen #(
    .XLEN    (32),
    .SHAMT_W (5)
  ) dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready32),
    .inst_i    (inst_i),
    .fmt_i     (fmt_i),
    .out_valid (out_valid32),
    .out_ready (out_ready),
    .imm_o     (imm32),
    .err_o     (err32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [2:0] f);
    in_valid = 1'b1;
    inst_i   = i;
    fmt_i    = f;
  endtask

  task automatic send(input logic [31:0] i, input logic [2:0] f);
    drive(i, f);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag,
                         input logic [63:0] imm,
                         input logic err);
    chk({tag, "_v"}, 64'(out_valid), 64'd1);
    chk({tag, "_imm"}, imm_o, imm);
    chk({tag, "_err"}, 64'(err_o), 64'(err));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    inst_i    = '0;
    fmt_i     = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_imm", imm_o, 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    send(32'hFFF00093, 3'd0);
    chk_out("I", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(32'h00A12423, 3'd1);
    chk_out("S", 64'd8, 1'b0);
    send(32'hFE000EE3, 3'd2);
    chk_out("B", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(32'h12345037, 3'd3);
    chk_out("U", 64'h0000_0000_1234_5000, 1'b0);
    send(32'h80000037, 3'd3);
    chk_out("Uneg", 64'hFFFF_FFFF_8000_0000, 1'b0);
    chk("Uneg32", 64'(imm32), 64'h8000_0000);
    send(32'h0080006F, 3'd4);
    chk_out("J", 64'd8, 1'b0);
    send(32'hFFDFF06F, 3'd4);
    chk_out("Jneg", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(32'h800F8073, 3'd5);
    chk_out("Z", 64'h1F, 1'b0);
    send(32'h83F00013, 3'd6);
    chk_out("SH", 64'h3F, 1'b0);
    chk("SH32", 64'(imm32), 64'h1F);
    send(32'hFFFFFFFF, 3'd7);
    chk_out("RSV", 64'd0, 1'b1);
    chk("RSV32e", 64'(err32), 64'd1);
    tick();
    chk("idle_ov", 64'(out_valid), 64'd0);

    // backpressure: A, B, C back-to-back with the consumer stalled
    out_ready = 1'b0;
    drive(32'h00100093, 3'd0);
    tick();
    chk("bp_A_ov", 64'(out_valid), 64'd1);
    drive(32'h00200093, 3'd0);
    tick();
    chk("bp_rdy0", 64'(in_ready), 64'd0);
    drive(32'h00300093, 3'd0);
    tick();
    chk("bp_hold1", imm_o, 64'd1);
    chk("bp_rdy0b", 64'(in_ready), 64'd0);
    tick();
    chk("bp_hold2", imm_o, 64'd1);
    chk("bp_ov", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    chk_out("bp_B", 64'd2, 1'b0);
    chk("bp_rdy1", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk_out("bp_C", 64'd3, 1'b0);
    tick();
    chk("bp_end", 64'(out_valid), 64'd0);

    // reset with both R and S occupied
    out_ready = 1'b0;
    send(32'h00500093, 3'd0);
    send(32'h00600093, 3'd0);
    chk("mr_rdy0", 64'(in_ready), 64'd0);
    chk("mr_ov1", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_ov", 64'(out_valid), 64'd0);
    chk("mr_imm", imm_o, 64'd0);
    chk("mr_rdy", 64'(in_ready), 64'd1);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mr_ov_rel", 64'(out_valid), 64'd0);
    send(32'h12345037, 3'd3);
    chk_out("mr_D", 64'h0000_0000_1234_5000, 1'b0);
    tick();
    chk("mr_end", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
